prism_loader: RTL
=================

PRISM_LOADER -- requirements
Module: prism_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets configuration-word FIFO depth (power of two, 2..16).
REQ-002 Parameter RST_CYCLES, default 2, sets cycles dbg_reset is held before the first load write.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cfg_push  input  1  push cfg_data into FIFO; cfg_data  input  32  configuration word.
REQ-006 cfg_full  output  1  FIFO full.
REQ-007 start  input  1  load-start pulse; load_base  input  6  first debug address; load_count  input  5  words to load (0..16).
REQ-008 run_after  input  1  set fsm_enable when load completes; abort  input  1  cancel load.
REQ-009 host_wr  input  1, host_addr  input  6, host_wdata  input  32  direct host debug write.
REQ-010 host_stall  output  1  host write refused this cycle.
REQ-011 dbg_wr  output  1, dbg_addr  output  6, dbg_wdata  output  32, dbg_reset  output  1, fsm_enable  output  1  PRISM debug/control port.
REQ-012 busy  output  1, done  output  1 (one-cycle pulse), err  output  1 (sticky overflow).

Function
REQ-013 States IDLE, RESET, WRITE, RELEASE; all dbg_* outputs registered (one-cycle latency from decision).
REQ-014 IDLE: host_wr forwarded next cycle to dbg_wr/dbg_addr/dbg_wdata; host_stall=0.
REQ-015 IDLE + start, load_count!=0: go RESET, fsm_enable<=0, dbg_reset<=1, err<=0, word index<=0, busy=1.
REQ-016 IDLE + start, load_count==0: stay IDLE, done pulses next cycle, no dbg activity, fsm_enable unchanged.
REQ-017 start and host_wr same IDLE cycle: start wins, host write dropped, host_stall=1.
REQ-018 Any host_wr while busy=1: host_stall=1 combinationally, write dropped.
REQ-019 RESET: hold dbg_reset=1 for RST_CYCLES cycles, then WRITE.
REQ-020 WRITE: each cycle FIFO non-empty -> pop, dbg_wr=1, dbg_wdata=word, dbg_addr=load_base+4*index (6-bit wrap-around); FIFO empty -> wait, dbg_wr=0, dbg_reset stays 1.
REQ-021 WRITE after load_count words issued: go RELEASE.
REQ-022 RELEASE (one cycle): dbg_reset<=0, fsm_enable<=run_after, done pulses, then IDLE.
REQ-023 load_base/load_count/run_after captured at accepted start; later changes ignored.
REQ-024 cfg_push while full: word dropped, err<=1; push and pop same cycle while full: accepted.
REQ-025 abort (any state except IDLE): next cycle IDLE, FIFO flushed, dbg_reset<=0, fsm_enable<=0, no done pulse; abort in IDLE flushes FIFO only.
REQ-026 Surplus FIFO words after load remain for next load.

Reset
REQ-027 rst=1: state IDLE, FIFO empty, dbg_wr=0, dbg_addr=0, dbg_wdata=0, dbg_reset=1, fsm_enable=0, busy=0, done=0, err=0, cfg_full=0.
REQ-028 First cycle after rst release: dbg_reset<=0; rst mid-load discards all progress.

Configuration
REQ-029 PRISM_LOADER_CSUM_EN defined: output csum[31:0] = 32-bit modulo sum of words written during current load, cleared at accepted start, valid from done.
REQ-030 PRISM_LOADER_CSUM_EN undefined: no csum port, no accumulator logic.

Structure
REQ-031 Package prism_loader_pkg holds state enum, ADDR_STEP=4, default FIFO_DEPTH and RST_CYCLES.
REQ-032 One sub-module prism_loader_fifo (synchronous FIFO, push/pop/flush, full/empty).

Verification
REQ-033 Push 3 words A,B,C; start base=0x10, count=3, run_after=1 -> dbg_reset 2 cycles, writes 0x10/0x14/0x18 data A/B/C, done, fsm_enable=1.
REQ-034 start count=4 with 1 word queued, push rest 5 cycles later -> WRITE waits, dbg_reset held, 4 writes total, done once.
REQ-035 base=0x38, count=3 -> addresses 0x38, 0x3C, 0x00.
REQ-036 Push 5 words into depth 4 -> cfg_full after 4, err=1, 5th dropped; next start clears err.
REQ-037 host_wr during load -> host_stall=1, no dbg_wr from host; abort mid-WRITE -> IDLE, FIFO empty, dbg_reset=0, no done.
REQ-038 CSUM_EN: load 0xFFFFFFFF and 0x00000002 -> csum=0x00000001.

Source files
------------

// File: rtl/prism_loader_pkg.sv
// Shared types and defaults for the PRISM configuration loader.
package prism_loader_pkg;

  typedef enum logic [1:0] {IDLE, RESET, WRITE, RELEASE} state_t;

  localparam logic [5:0] ADDR_STEP      = 6'd4;
  localparam int         DEF_FIFO_DEPTH = 4;
  localparam int         DEF_RST_CYCLES = 2;

endpackage

// File: rtl/prism_loader_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module prism_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/prism_loader.sv
// Loads queued configuration words into the PRISM debug port under reset.
// Optional PRISM_LOADER_CSUM_EN adds a running 32-bit sum of loaded words.
module prism_loader
  import prism_loader_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_push,
  input  logic [31:0] cfg_data,
  output logic        cfg_full,
  input  logic        start,
  input  logic [5:0]  load_base,
  input  logic [4:0]  load_count,
  input  logic        run_after,
  input  logic        abort,
  input  logic        host_wr,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_stall,
  output logic        dbg_wr,
  output logic [5:0]  dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        dbg_reset,
  output logic        fsm_enable,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef PRISM_LOADER_CSUM_EN
  ,
  output logic [31:0] csum
`endif
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t          state;
  logic [RCW-1:0]  rst_cnt;
  logic [4:0]      count_q;
  logic [4:0]      issued;
  logic [5:0]      next_addr;
  logic            run_q;
  logic [31:0]     fifo_rdata;
  logic            fifo_empty;
  logic            accept;
  logic            rst_last;
  logic            issue;
  logic            last_word;
  logic            overflow;

  prism_loader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cfg_push),
    .pop   (issue),
    .flush (abort),
    .wdata (cfg_data),
    .rdata (fifo_rdata),
    .full  (cfg_full),
    .empty (fifo_empty)
  );

  // The first pop is decided in the last RESET cycle so dbg_reset is seen
  // alone for exactly RST_CYCLES cycles before the first write.
  assign busy       = (state != IDLE);
  assign accept     = (state == IDLE) && start && !abort;
  assign host_stall = host_wr && (busy || start);
  assign rst_last   = (rst_cnt == RST_LAST);
  assign issue      = !abort && !fifo_empty &&
                      ((state == WRITE) || ((state == RESET) && rst_last));
  assign last_word  = issue && ((issued + 5'd1) == count_q);
  assign overflow   = cfg_push && cfg_full && !issue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      count_q    <= '0;
      issued     <= '0;
      next_addr  <= '0;
      run_q      <= 1'b0;
      dbg_wr     <= 1'b0;
      dbg_addr   <= '0;
      dbg_wdata  <= '0;
      dbg_reset  <= 1'b1;
      fsm_enable <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      dbg_wr <= 1'b0;
      done   <= 1'b0;
      if (abort && state != IDLE) begin
        state      <= IDLE;
        dbg_reset  <= 1'b0;
        fsm_enable <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dbg_reset <= 1'b0;
            if (accept) begin
              if (load_count != 5'd0) begin
                state      <= RESET;
                fsm_enable <= 1'b0;
                dbg_reset  <= 1'b1;
                err        <= 1'b0;
                issued     <= '0;
                rst_cnt    <= '0;
                next_addr  <= load_base;
                count_q    <= load_count;
                run_q      <= run_after;
              end else begin
                done <= 1'b1;
              end
            end else if (host_wr && !start) begin
              dbg_wr    <= 1'b1;
              dbg_addr  <= host_addr;
              dbg_wdata <= host_wdata;
            end
          end
          RESET: begin
            if (rst_last) state <= WRITE;
            else          rst_cnt <= rst_cnt + RCW'(1);
          end
          WRITE: ;
          RELEASE: begin
            dbg_reset  <= 1'b0;
            fsm_enable <= run_q;
            done       <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
        if (issue) begin
          dbg_wr    <= 1'b1;
          dbg_addr  <= next_addr;
          dbg_wdata <= fifo_rdata;
          next_addr <= next_addr + ADDR_STEP;
          issued    <= issued + 5'd1;
          if (last_word) state <= RELEASE;
        end
      end
      if (overflow) err <= 1'b1;
    end
  end

`ifdef PRISM_LOADER_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         csum <= '0;
    else if (accept) csum <= '0;
    else if (issue)  csum <= csum + fifo_rdata;
  end
`endif

endmodule
